// File: rtl/sd_cic_decimator.sv
// Third-order CIC decimator for the 2-bit ternary sigma-delta bitstream; emits signed PCM at 1/DECIM rate.
// Optional output clamping is enabled by defining SD_CIC_SAT_EN; otherwise the output wraps.
module sd_cic_decimator #(
  parameter int DECIM     = 64,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [1:0]                  sd_in,
  output logic signed [OUT_WIDTH-1:0] pcm_out,
  output logic                        pcm_valid
);

  localparam int CNT_W = $clog2(DECIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  function automatic logic signed [1:0] map_in(input logic [1:0] b);
    case (b)
      2'b01:   return 2'sb01;
      2'b10:   return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] reduce_out(input logic signed [ACC_WIDTH-1:0] v);
`ifdef SD_CIC_SAT_EN
    logic [ACC_WIDTH-OUT_WIDTH:0] top;
    top = v[ACC_WIDTH-1:OUT_WIDTH-1];
    if (top == '0 || top == '1)
      return OUT_WIDTH'(v);
    else if (v[ACC_WIDTH-1])
      return {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
    return OUT_WIDTH'(v);
`endif
  endfunction

  logic signed [1:0]           x_p0;
  logic signed [ACC_WIDTH-1:0] x_ext;
  logic signed [ACC_WIDTH-1:0] i1, i2, i3;
  logic [CNT_W-1:0]            cnt;
  logic signed [ACC_WIDTH-1:0] dec_p0, dec_d, c1_p1, c1_d, c2_p2, c2_d, c3_p3;
  logic signed [ACC_WIDTH-1:0] y_p3;
  logic                        vld_p0, vld_p1, vld_p2, vld_p3;

  assign x_ext = {{(ACC_WIDTH-2){x_p0[1]}}, x_p0};
  assign y_p3  = c3_p3 >>> SHIFT;

  // Everything, data included, is cleared on reset so no pre-reset sample can leak out.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_p0      <= '0;
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      cnt       <= '0;
      dec_p0    <= '0;
      dec_d     <= '0;
      c1_p1     <= '0;
      c1_d      <= '0;
      c2_p2     <= '0;
      c2_d      <= '0;
      c3_p3     <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
    end else begin
      // Stage p0: input register, wrapping integrators, decimation strobe
      vld_p0 <= 1'b0;
      if (en) begin
        x_p0 <= map_in(sd_in);
        i1   <= i1 + x_ext;
        i2   <= i2 + i1;
        i3   <= i3 + i2;
        if (cnt == CNT_LAST) begin
          cnt    <= '0;
          dec_p0 <= i3;
          vld_p0 <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      // Stage p1: first comb
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        c1_p1 <= dec_p0 - dec_d;
        dec_d <= dec_p0;
      end

      // Stage p2: second comb
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        c2_p2 <= c1_p1 - c1_d;
        c1_d  <= c1_p1;
      end

      // Stage p3: third comb
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        c3_p3 <= c2_p2 - c2_d;
        c2_d  <= c2_p2;
      end

      // Output stage: scale and reduce to PCM width
      pcm_valid <= vld_p3;
      if (vld_p3)
        pcm_out <= reduce_out(y_p3);
    end
  end

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Directed bench for sd_cic_decimator: pulse timing, steady-state DC values and mid-stream reset.
module tb_sd_cic_decimator;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [1:0]        sd_in;
  logic signed [15:0] pcm_out;
  logic              pcm_valid;

  int n_checks = 0;
  int n_fail   = 0;

  int     pe[16];
  longint pv[16];
  int     np;

`ifdef SD_CIC_SAT_EN
  localparam longint POS_DC = 32767;
`else
  localparam longint POS_DC = -32768;
`endif

  sd_cic_decimator #(.DECIM(64), .ACC_WIDTH(24), .OUT_WIDTH(16), .SHIFT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sd_in     (sd_in),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    en    = 1'b0;
    sd_in = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({name, "_rst_valid"}, longint'(pcm_valid), 0);
    chk({name, "_rst_out"}, longint'(pcm_out), 0);
    reset = 1'b0;
  endtask

  task automatic run_stream(input string name, input logic [1:0] a, input logic [1:0] b,
                            input bit tog, input int first, input int period, input int npulse,
                            input bit chk_all, input longint expv);
    int ncyc;
    do_reset(name);
    sd_in = a;
    en    = 1'b1;
    np    = 0;
    ncyc  = first + (npulse - 1) * period + 2;
    for (int e = 1; e <= ncyc; e++) begin
      @(posedge clk); #1;
      if (pcm_valid) begin
        if (np < 16) begin
          pe[np] = e;
          pv[np] = pcm_out;
        end
        np++;
      end
      sd_in = (e % 2 == 1) ? b : a;
      en    = tog ? (e % 2 == 0) : 1'b1;
    end
    chk({name, "_npulse"}, np, npulse);
    for (int k = 0; k < npulse && k < np && k < 16; k++) begin
      chk($sformatf("%s_edge%0d", name, k), pe[k], first + k * period);
      if (chk_all || k >= 3)
        chk($sformatf("%s_val%0d", name, k), pv[k], expv);
    end
  endtask

  task automatic run_mid_reset();
    int first_pulse;
    int nz_before;
    do_reset("midrst");
    sd_in = 2'b01;
    en    = 1'b1;
    first_pulse = -1;
    for (int e = 1; e <= 99; e++) begin
      @(posedge clk); #1;
      if (pcm_valid && first_pulse < 0) first_pulse = e;
    end
    chk("midrst_pre_pulse", first_pulse, 68);
    reset = 1'b1;
    en    = 1'b0;
    @(posedge clk); #1;
    chk("midrst_clr_valid", longint'(pcm_valid), 0);
    chk("midrst_clr_out", longint'(pcm_out), 0);
    reset = 1'b0;
    en    = 1'b1;
    first_pulse = -1;
    nz_before   = 0;
    for (int e = 1; e <= 80; e++) begin
      @(posedge clk); #1;
      if (pcm_valid && first_pulse < 0) first_pulse = e;
      if (first_pulse < 0 && pcm_out != 0) nz_before++;
    end
    chk("midrst_post_pulse", first_pulse, 68);
    chk("midrst_out_zero_before", nz_before, 0);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    sd_in = 2'b00;
    run_stream("zero",  2'b00, 2'b00, 1'b0, 68, 64, 5, 1'b1, 0);
    run_stream("pos",   2'b01, 2'b01, 1'b0, 68, 64, 6, 1'b0, POS_DC);
    run_stream("neg",   2'b10, 2'b10, 1'b0, 68, 64, 6, 1'b0, -32768);
    run_stream("b11",   2'b11, 2'b11, 1'b0, 68, 64, 5, 1'b0, 0);
    run_stream("alt",   2'b01, 2'b10, 1'b0, 68, 64, 6, 1'b0, 0);
    run_stream("entog", 2'b01, 2'b01, 1'b1, 131, 128, 5, 1'b0, POS_DC);
    run_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
